// File: rtl/rf_pkg.sv
//------------------------------------------------------------------------------
// Module      : rf_pkg
// Description : Shared constants and helpers for the register-file access path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rf_pkg;

    localparam int RF_ADDR_W = 2;
    localparam int RF_MAX_RD = 8;

    // Number of one-hot lines needed to decode an n-bit register address
    function automatic int rf_onehot_w(input int n);
        return 1 << n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_dec.sv
//------------------------------------------------------------------------------
// Module      : onehot_dec
// Description : Combinational address-to-one-hot decoder with enable.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module onehot_dec
    import rf_pkg::*;
#(
    parameter int N = RF_ADDR_W
) (
    input  logic [N-1:0]              adr,
    input  logic                      ena,
    output logic [rf_onehot_w(N)-1:0] onehot
);

    localparam int M = rf_onehot_w(N);

    assign onehot = ena ? (M'(1) << adr) : '0;

endmodule

`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
//------------------------------------------------------------------------------
// Module      : regfile_access_ctrl
// Description : Registered one-hot read/write enables, RAW hazard flags and a
//               written-since-clear bitmap. Optional macro REGFILE_BYPASS_EN
//               suppresses the array read enable on hazard ports.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_access_ctrl
    import rf_pkg::*;
#(
    parameter int N      = RF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                               Clk,
    input  logic                               Rst_n,
    input  logic [NUM_RD*N-1:0]                Rd_adr,
    input  logic [NUM_RD-1:0]                  Rd_ena,
    input  logic [N-1:0]                       Wr_adr,
    input  logic                               Wr_ena,
    input  logic                               Clr,
    output logic [NUM_RD*rf_onehot_w(N)-1:0]   Oe,
    output logic [rf_onehot_w(N)-1:0]          We,
    output logic [NUM_RD-1:0]                  Fwd,
    output logic [NUM_RD-1:0]                  Uninit,
    output logic [rf_onehot_w(N)-1:0]          Written
);

    localparam int M = rf_onehot_w(N);

    logic [NUM_RD*M-1:0] w_rd_oh;
    logic [NUM_RD*M-1:0] w_oe_nxt;
    logic [M-1:0]        w_wr_oh;
    logic [M-1:0]        w_written_nxt;
    logic [NUM_RD-1:0]   w_fwd_nxt;
    logic [NUM_RD-1:0]   w_uninit_nxt;

    logic [NUM_RD*M-1:0] r_oe;
    logic [M-1:0]        r_we;
    logic [NUM_RD-1:0]   r_fwd;
    logic [NUM_RD-1:0]   r_uninit;
    logic [M-1:0]        r_written;

    onehot_dec #(.N(N)) u_wr_dec (
        .adr    (Wr_adr),
        .ena    (Wr_ena),
        .onehot (w_wr_oh)
    );

    // A same-edge write is already visible to this edge's uninit check
    assign w_written_nxt = (Clr ? '0 : r_written) | w_wr_oh;

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
            onehot_dec #(.N(N)) u_rd_dec (
                .adr    (Rd_adr[p*N +: N]),
                .ena    (Rd_ena[p]),
                .onehot (w_rd_oh[p*M +: M])
            );

            assign w_fwd_nxt[p]    = Rd_ena[p] & Wr_ena & (Rd_adr[p*N +: N] == Wr_adr);
            assign w_uninit_nxt[p] = Rd_ena[p] & ~w_written_nxt[Rd_adr[p*N +: N]];

`ifdef REGFILE_BYPASS_EN
            // Bypass path owns the read bus, so the array buffer must stay off
            assign w_oe_nxt[p*M +: M] = w_fwd_nxt[p] ? '0 : w_rd_oh[p*M +: M];
`else
            assign w_oe_nxt[p*M +: M] = w_rd_oh[p*M +: M];
`endif
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_oe      <= '0;
            r_we      <= '0;
            r_fwd     <= '0;
            r_uninit  <= '0;
            r_written <= '0;
        end else begin
            r_oe      <= w_oe_nxt;
            r_we      <= w_wr_oh;
            r_fwd     <= w_fwd_nxt;
            r_uninit  <= w_uninit_nxt;
            r_written <= w_written_nxt;
        end
    end

    assign Oe      = r_oe;
    assign We      = r_we;
    assign Fwd     = r_fwd;
    assign Uninit  = r_uninit;
    assign Written = r_written;

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_regfile_access_ctrl
// Description : Scoreboard bench for regfile_access_ctrl (N=2, NUM_RD=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_access_ctrl;

    logic       Clk;
    logic       Rst_n;
    logic [3:0] Rd_adr;
    logic [1:0] Rd_ena;
    logic [1:0] Wr_adr;
    logic       Wr_ena;
    logic       Clr;
    logic [7:0] Oe;
    logic [3:0] We;
    logic [1:0] Fwd;
    logic [1:0] Uninit;
    logic [3:0] Written;

    typedef struct packed {
        logic [7:0] oe;
        logic [3:0] we;
        logic [1:0] fwd;
        logic [1:0] un;
        logic [3:0] wr;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_written;
    int         n_tests;
    int         n_fail;

    regfile_access_ctrl #(.N(2), .NUM_RD(2)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Rd_adr  (Rd_adr),
        .Rd_ena  (Rd_ena),
        .Wr_adr  (Wr_adr),
        .Wr_ena  (Wr_ena),
        .Clr     (Clr),
        .Oe      (Oe),
        .We      (We),
        .Fwd     (Fwd),
        .Uninit  (Uninit),
        .Written (Written)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict the registered outputs, compare after the edge
    task automatic step(input logic [3:0] ra, input logic [1:0] re, input logic [1:0] wa,
                        input logic we_i, input logic clr);
        exp_t       e;
        logic [3:0] wmask;
        logic [3:0] wn;
        logic [1:0] a;
        @(negedge Clk);
        Rd_adr = ra; Rd_ena = re; Wr_adr = wa; Wr_ena = we_i; Clr = clr;
        wmask = we_i ? (4'b0001 << wa) : 4'b0000;
        wn    = (clr ? 4'b0000 : m_written) | wmask;
        e     = '0;
        for (int p = 0; p < 2; p++) begin
            a          = ra[p*2 +: 2];
            e.fwd[p]   = re[p] & we_i & (a == wa);
            e.un[p]    = re[p] & ~wn[a];
            e.oe[p*4 +: 4] = re[p] ? (4'b0001 << a) : 4'b0000;
`ifdef REGFILE_BYPASS_EN
            if (e.fwd[p]) e.oe[p*4 +: 4] = 4'b0000;
`endif
        end
        e.we = wmask;
        e.wr = wn;
        sb.push_back(e);
        m_written = wn;
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("oe",      {24'd0, Oe},      {24'd0, e.oe});
            check("we",      {28'd0, We},      {28'd0, e.we});
            check("fwd",     {30'd0, Fwd},     {30'd0, e.fwd});
            check("uninit",  {30'd0, Uninit},  {30'd0, e.un});
            check("written", {28'd0, Written}, {28'd0, e.wr});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_oe"},      {24'd0, Oe},      32'd0);
        check({tag, "_we"},      {28'd0, We},      32'd0);
        check({tag, "_fwd"},     {30'd0, Fwd},     32'd0);
        check({tag, "_uninit"},  {30'd0, Uninit},  32'd0);
        check({tag, "_written"}, {28'd0, Written}, 32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_written = 4'b0000;
        Rst_n  = 1'b1;
        Rd_adr = 4'b1101; Rd_ena = 2'b11; Wr_adr = 2'd0; Wr_ena = 1'b1; Clr = 1'b0;
        #2 Rst_n = 1'b0;

        // Reset held with active inputs
        repeat (3) @(posedge Clk);
        #1 check_all_zero("rst_hold");
        @(negedge Clk) Rst_n = 1'b1;
        step(4'b1101, 2'b11, 2'd0, 1'b1, 1'b0);
        check("rst_release_we", {28'd0, We}, 32'h1);

        // Independent reads (clear bitmap at the same time)
        step(4'b1101, 2'b11, 2'd0, 1'b0, 1'b1);
        check("indep_oe_both", {24'd0, Oe}, 32'h82);
        step(4'b1101, 2'b01, 2'd0, 1'b0, 1'b0);
        check("indep_oe_p0", {24'd0, Oe}, 32'h02);

        // Write, bitmap and uninit
        step(4'b0010, 2'b01, 2'd0, 1'b0, 1'b0);
        check("uninit_before_wr", {31'd0, Uninit[0]}, 32'd1);
        step(4'b0000, 2'b00, 2'd2, 1'b1, 1'b0);
        check("wr_we", {28'd0, We}, 32'h4);
        check("wr_written", {28'd0, Written}, 32'h4);
        step(4'b0010, 2'b01, 2'd0, 1'b0, 1'b0);
        check("uninit_after_wr", {31'd0, Uninit[0]}, 32'd0);

        // Same-cycle read-after-write on both ports
        step(4'b0101, 2'b11, 2'd1, 1'b1, 1'b0);
        check("haz_fwd", {30'd0, Fwd}, 32'h3);
        check("haz_uninit", {30'd0, Uninit}, 32'h0);
`ifdef REGFILE_BYPASS_EN
        check("haz_oe", {24'd0, Oe}, 32'h00);
`else
        check("haz_oe", {24'd0, Oe}, 32'h22);
`endif

        // Clear together with a write
        step(4'b0000, 2'b00, 2'd0, 1'b1, 1'b1);
        step(4'b0000, 2'b00, 2'd1, 1'b1, 1'b0);
        step(4'b0000, 2'b00, 2'd3, 1'b1, 1'b0);
        check("pre_clr_written", {28'd0, Written}, 32'hB);
        step(4'b0000, 2'b01, 2'd2, 1'b1, 1'b1);
        check("clr_wr_written", {28'd0, Written}, 32'h4);
        check("clr_wr_uninit", {31'd0, Uninit[0]}, 32'd1);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            step(4'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset mid-operation
        for (int a = 0; a < 4; a++) step(4'b1001, 2'b11, 2'(a), 1'b1, 1'b0);
        check("pre_rst_written", {28'd0, Written}, 32'hF);
        #3 Rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        m_written = 4'b0000;
        sb.delete();
        @(negedge Clk) Rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(4'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Parametrised access controller for the register file. It generalises the dual-port read decoder to NUM_RD read ports and one write port. All one-hot enables are registered, so reads and writes reach the register array in the same phase. The block also keeps a written-since-clear bitmap and flags read-after-write hazards per port. It sits between the instruction decode stage and the register array / tri-state read buffers.

Parameters:
N, 2, address width; register count M = 2**N (localparam)
NUM_RD, 2, number of independent read ports (1..8)

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous active-low reset
Rd_adr  in  NUM_RD*N  packed read addresses; port p occupies [p*N +: N]
Rd_ena  in  NUM_RD  per-port read enable
Wr_adr  in  N  write address
Wr_ena  in  1  write enable
Clr  in  1  synchronous clear of the written bitmap
Oe  out  NUM_RD*M  registered one-hot read enables; port p occupies [p*M +: M]
We  out  M  registered one-hot write enable
Fwd  out  NUM_RD  registered read-after-write hazard flag per port
Uninit  out  NUM_RD  registered "read of never-written register" flag per port
Written  out  M  registered bitmap of registers written since reset/Clr

Behaviour:
- One clock; reset is asynchronous and active-low (Rst_n). It may assert at any time, including mid-operation.
- Reset values: Oe=0, We=0, Fwd=0, Uninit=0, Written=0. Rst_n has priority over every other input.
- Latency is 1 cycle for every output. Inputs sampled at edge k appear on outputs after edge k.
- Read port p:
  - Rd_ena[p]=1: next Oe slice p = 1 << Rd_adr[p].
  - Rd_ena[p]=0: the slice is all zeros.
  - Ports are fully independent. Several ports may select the same register in the same cycle.
- Write: Wr_ena=1 gives next We = 1 << Wr_adr; Wr_ena=0 gives We = 0.
- Hazard: next Fwd[p] = Rd_ena[p] & Wr_ena & (Rd_adr[p]==Wr_adr). It is evaluated per port, so several ports can flag at once.
- Written bitmap:
  - next Written = (Clr ? 0 : Written) | (Wr_ena ? 1<<Wr_adr : 0).
  - When Clr and a write occur together, the written bit survives and all other bits clear.
- Uninit: next Uninit[p] = Rd_ena[p] & ~Written_eff[Rd_adr[p]], where Written_eff is the bitmap value being loaded this edge.
  - A same-cycle write to the read address therefore suppresses Uninit.
  - Clr in the same cycle makes all other addresses read as uninitialised.
- Addresses always lie in range (M = 2**N), so no out-of-range case exists.
- Outputs are never X after reset, including for NUM_RD=1.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: when Fwd[p] is set, the Oe slice p for that cycle is forced to all zeros. The datapath drives the write data onto read bus p instead, so the array buffer and the bypass never both drive the bus.
- Undefined: the Oe slice is driven normally and the read returns the pre-write value. Fwd is still reported, as information only.
- Both builds must give identical We, Written and Uninit behaviour.

Decomposition:
- Shared package rf_pkg: the RF_ADDR_W default (2), the RF_MAX_RD limit (8), and a constant function for the one-hot width (2**N).
- One natural sub-module: onehot_dec (parameter N; inputs adr, ena; output one-hot M bits; combinational). It is instantiated NUM_RD+1 times, once per read port and once for the write port.
- Registering, hazard compare and the bitmap stay in the top module.

Test Plan:
- Reset: hold Rst_n=0 with Rd_ena=2'b11, Wr_ena=1 → all outputs 0. Deassert Rst_n, then after one edge Oe/We reflect the inputs.
- Independent reads: N=2, NUM_RD=2, Rd_adr={2'd3,2'd1}, Rd_ena=2'b11 → after one edge Oe = {4'b1000,4'b0010}. Set Rd_ena=2'b01 → Oe = {4'b0000,4'b0010}.
- Write, bitmap and Uninit:
  - After reset, read port 0 at address 2 → Uninit[0]=1.
  - Write address 2 → We=4'b0100, Written=4'b0100.
  - Read address 2 again → Uninit[0]=0.
- Same-cycle hazard: Wr_adr=1, Wr_ena=1; port 0 reads 1, port 1 reads 1 → Fwd=2'b11, Uninit=2'b00.
  - With REGFILE_BYPASS_EN: Oe=0.
  - Without it: Oe = {4'b0010,4'b0010}.
- Clr with write: Written=4'b1011; assert Clr with a write to address 2 → Written=4'b0100. A read of 0 in that cycle gives Uninit=1.
- Reset mid-operation: pulse Rst_n low between edges while Written=4'b1111 → Written, Oe, We, Fwd and Uninit drop to 0 immediately, without waiting for a clock edge.
